player_anim_addr_gen: RTL and testbench
=======================================

// Module: player_anim_addr_gen
// PURPOSE
//  Animation address generator for one player sprite sheet. Sits directly upstream of the player
//  animation mux. Steps through NUM_FRAMES animation frames at a rate set by frame_clk (vsync).
//  For every scanned pixel it produces the sprite-ROM address and a playerOn hit flag, plus the
//  sprite height/width that the mux forwards.
//  One instance per animation (run, jump, prone, ...), each with its own parameters.
// PARAMETERS
//  BASE_ADDR   21'd0  first ROM word of frame 0 of this animation
//  SPRITE_W    32     sprite width in pixels (1..255)
//  SPRITE_H    48     sprite height in pixels (1..255)
//  NUM_FRAMES  6      frames in the animation cycle (1..16)
//  FRAME_DIV   4      frame_clk ticks per animation frame (1..255)
// PORTS
//  Clk          in   1   system clock (50 MHz pixel-domain clock)
//  Reset        in   1   asynchronous, active-high reset
//  frame_clk    in   1   vsync-rate frame clock; a rising edge is one frame tick
//  enable       in   1   1 = animation advances; 0 = current frame is held
//  restart      in   1   synchronous pulse: return to frame 0
//  DrawX        in   10  current scan column (0..639)
//  DrawY        in   10  current scan row (0..479)
//  PlayerX      in   10  sprite top-left column
//  PlayerY      in   10  sprite top-left row
//  address      out  21  sprite ROM address for (DrawX,DrawY), registered
//  playerOn     out  1   1 = (DrawX,DrawY) lies inside the sprite box, registered
//  playerHeight out  10  constant SPRITE_H
//  playerWidth  out  10  constant SPRITE_W
//  frameIndex   out  4   current animation frame, 0..NUM_FRAMES-1
// BEHAVIOUR
//  Reset (async, high):
//   - frame_clk_d, div_cnt, frameIndex, address and playerOn all clear to 0.
//   - playerHeight and playerWidth are constants and are unaffected by reset.
//   - Reset asserted mid-animation returns the block to frame 0 immediately.
//  Tick detect:
//   - frame_clk_d <= frame_clk on every Clk.
//   - tick = frame_clk & ~frame_clk_d, a one-Clk pulse per frame_clk rising edge.
//  Frame sequencer (counters update on Clk, in priority order):
//   1. restart = 1: div_cnt <= 0 and frameIndex <= 0 on the next edge. Overrides a coincident tick.
//   2. else tick & enable:
//      - div_cnt == FRAME_DIV-1: div_cnt <= 0 and frameIndex advances.
//      - frameIndex advances by +1 and wraps from NUM_FRAMES-1 to 0.
//      - otherwise div_cnt <= div_cnt + 1.
//   3. else (including enable = 0): both counters hold.
//  Pixel path (1-Clk latency from DrawX/DrawY/PlayerX/PlayerY to address/playerOn):
//   - Box compare done in 11-bit arithmetic so there is no wrap near the 640/480 edges:
//     in = (DrawX >= PlayerX) & ({1'b0,DrawX} < PlayerX+SPRITE_W)
//          & (DrawY >= PlayerY) & ({1'b0,DrawY} < PlayerY+SPRITE_H).
//   - relX = DrawX-PlayerX and relY = DrawY-PlayerY, 8 bits each (valid only when in).
//   - When in: address <= BASE_ADDR + frameIndex*SPRITE_W*SPRITE_H + relY*SPRITE_W + relX,
//     truncated to 21 bits; playerOn <= 1.
//   - When not in: address <= BASE_ADDR and playerOn <= 0.
//   - The address uses the frameIndex register value in the same cycle. A frame change
//     therefore takes effect on the next pixel, even mid-line.
// TESTING
//  (defaults, BASE_ADDR=0; one frame = 1536 words)
//  1 Hit: PlayerX=100, PlayerY=200, DrawX=105, DrawY=210, frame 0
//    -> next Clk address=325, playerOn=1.
//  2 Box edges: same player; DrawX=131 -> playerOn=1; DrawX=132 -> playerOn=0, address=0;
//    DrawY=247 -> playerOn=1; DrawY=248 -> playerOn=0.
//  3 Frame advance: 4 frame_clk pulses with enable=1 -> frameIndex=1, case-1 address=1861;
//    24 pulses total -> frameIndex returns to 0.
//  4 Hold and restart: enable=0 for 8 pulses -> frameIndex unchanged;
//    restart coincident with a wrapping tick -> frameIndex=0 and div_cnt=0.
//  5 Screen edge: PlayerX=620, DrawX=639 -> playerOn=1, relX=19; DrawX=5 -> playerOn=0
//    (no 10-bit wrap).
//  6 Reset mid-operation: frameIndex=3, playerOn=1, assert Reset between Clk edges
//    -> all outputs 0 immediately; first tick after release counts from div_cnt=0.

Source files
------------

// File: rtl/player_anim_addr_gen_if.sv
// rtl/player_anim_addr_gen_if.sv - pixel query bus between scan logic and the animation address generator
// Master supplies scan/sprite position; slave returns ROM address, hit flag and sprite size.
interface player_anim_addr_gen_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  PlayerX;
  logic [9:0]  PlayerY;
  logic [20:0] address;
  logic        playerOn;
  logic [9:0]  playerHeight;
  logic [9:0]  playerWidth;

  modport master (
    output DrawX, DrawY, PlayerX, PlayerY,
    input  address, playerOn, playerHeight, playerWidth
  );

  modport slave (
    input  DrawX, DrawY, PlayerX, PlayerY,
    output address, playerOn, playerHeight, playerWidth
  );
endinterface

// File: rtl/player_anim_addr_gen.sv
// rtl/player_anim_addr_gen.sv - sprite-sheet animation frame sequencer and per-pixel ROM address generator
// One instance per animation; frame_clk rising edges pace the frames, DrawX/DrawY map to a ROM word.
module player_anim_addr_gen #(
  parameter logic [20:0] BASE_ADDR  = 21'd0,
  parameter int          SPRITE_W   = 32,
  parameter int          SPRITE_H   = 48,
  parameter int          NUM_FRAMES = 6,
  parameter int          FRAME_DIV  = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic                  enable,
  input  logic                  restart,
  output logic [3:0]            frameIndex,
  player_anim_addr_gen_if.slave pix
);

  localparam logic [20:0] FRAME_WORDS = 21'(SPRITE_W * SPRITE_H);
  localparam logic [7:0]  DIV_LAST    = 8'(FRAME_DIV - 1);
  localparam logic [3:0]  FRAME_LAST  = 4'(NUM_FRAMES - 1);
  localparam logic [10:0] W11         = 11'(SPRITE_W);
  localparam logic [10:0] H11         = 11'(SPRITE_H);

  logic       frameClkD;
  logic       tick;
  logic [7:0] divCnt;

  assign tick = frame_clk & ~frameClkD;

  // restart wins over a coincident tick; enable low freezes both counters
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frameClkD  <= 1'b0;
      divCnt     <= 8'd0;
      frameIndex <= 4'd0;
    end else begin
      frameClkD <= frame_clk;
      if (restart) begin
        divCnt     <= 8'd0;
        frameIndex <= 4'd0;
      end else if (tick && enable) begin
        if (divCnt == DIV_LAST) begin
          divCnt     <= 8'd0;
          frameIndex <= (frameIndex == FRAME_LAST) ? 4'd0 : frameIndex + 4'd1;
        end else begin
          divCnt <= divCnt + 8'd1;
        end
      end
    end
  end

  logic [10:0] xEnd;
  logic [10:0] yEnd;
  logic        inBox;
  logic [7:0]  relX;
  logic [7:0]  relY;
  logic [20:0] hitAddr;

  // 11-bit box ends so a sprite hanging off the right/bottom edge cannot wrap to column/row 0
  assign xEnd  = {1'b0, pix.PlayerX} + W11;
  assign yEnd  = {1'b0, pix.PlayerY} + H11;
  assign inBox = (pix.DrawX >= pix.PlayerX) && ({1'b0, pix.DrawX} < xEnd) &&
                 (pix.DrawY >= pix.PlayerY) && ({1'b0, pix.DrawY} < yEnd);
  assign relX  = 8'(pix.DrawX - pix.PlayerX);
  assign relY  = 8'(pix.DrawY - pix.PlayerY);

  assign hitAddr = BASE_ADDR
                 + 21'(frameIndex) * FRAME_WORDS
                 + 21'(relY) * 21'(SPRITE_W)
                 + 21'(relX);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix.address  <= 21'd0;
      pix.playerOn <= 1'b0;
    end else if (inBox) begin
      pix.address  <= hitAddr;
      pix.playerOn <= 1'b1;
    end else begin
      pix.address  <= BASE_ADDR;
      pix.playerOn <= 1'b0;
    end
  end

  assign pix.playerHeight = 10'(SPRITE_H);
  assign pix.playerWidth  = 10'(SPRITE_W);

endmodule

// File: tb/tb_player_anim_addr_gen.sv
// tb/tb_player_anim_addr_gen.sv - directed scoreboard bench for player_anim_addr_gen
// Default parameters: 32x48 sprite, 6 frames, 4 frame_clk ticks per frame, BASE_ADDR 0.
module tb_player_anim_addr_gen;
  localparam int W = 32;
  localparam int H = 48;
  localparam int NF = 6;
  localparam int DIV = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       enable = 1'b1;
  logic       restart = 1'b0;
  logic [3:0] frameIndex;

  player_anim_addr_gen_if pix ();

  player_anim_addr_gen dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .enable    (enable),
    .restart   (restart),
    .frameIndex(frameIndex),
    .pix       (pix)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [20:0] addr;
    logic        on;
  } exp_t;

  exp_t expQ[$];
  int   nAsserts = 0;
  int   nFails = 0;
  int   mFrame = 0;
  int   mDiv = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int dx, input int dy, input int px, input int py, input int frm);
    exp_t e;
    if (dx >= px && dx < px + W && dy >= py && dy < py + H) begin
      e.addr = 21'(frm * W * H + (dy - py) * W + (dx - px));
      e.on   = 1'b1;
    end else begin
      e.addr = 21'd0;
      e.on   = 1'b0;
    end
    return e;
  endfunction

  // drive one pixel at a negedge, score it one Clk later at the following negedge
  task automatic pixel(input string tag, input int dx, input int dy, input int px, input int py);
    exp_t e;
    pix.DrawX   = 10'(dx);
    pix.DrawY   = 10'(dy);
    pix.PlayerX = 10'(px);
    pix.PlayerY = 10'(py);
    expQ.push_back(model(dx, dy, px, py, mFrame));
    @(negedge Clk);
    e = expQ.pop_front();
    check({tag, ".addr"}, 32'(pix.address), 32'(e.addr));
    check({tag, ".on"}, 32'(pix.playerOn), 32'(e.on));
  endtask

  task automatic pulses(input int n, input logic rst);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      restart   = rst;
      @(negedge Clk);
      frame_clk = 1'b0;
      restart   = 1'b0;
      if (rst) begin
        mDiv = 0;
        mFrame = 0;
      end else if (enable) begin
        if (mDiv == DIV - 1) begin
          mDiv = 0;
          mFrame = (mFrame + 1) % NF;
        end else begin
          mDiv++;
        end
      end
      @(negedge Clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    pix.DrawX = 10'd0;
    pix.DrawY = 10'd0;
    pix.PlayerX = 10'd100;
    pix.PlayerY = 10'd200;
    #2;
    check("rst.addr", 32'(pix.address), 32'd0);
    check("rst.on", 32'(pix.playerOn), 32'd0);
    check("rst.frame", 32'(frameIndex), 32'd0);
    check("height", 32'(pix.playerHeight), 32'd48);
    check("width", 32'(pix.playerWidth), 32'd32);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    pixel("hit", 105, 210, 100, 200);
    check("hit.lit", 32'(pix.address), 32'd325);
    pixel("edgeR.in", 131, 210, 100, 200);
    pixel("edgeR.out", 132, 210, 100, 200);
    pixel("edgeL.out", 99, 210, 100, 200);
    pixel("edgeB.in", 105, 247, 100, 200);
    pixel("edgeB.out", 105, 248, 100, 200);
    pixel("edgeT.out", 105, 199, 100, 200);

    pulses(4, 1'b0);
    check("adv.frame", 32'(frameIndex), 32'(mFrame));
    pixel("adv.hit", 105, 210, 100, 200);
    check("adv.lit", 32'(pix.address), 32'd1861);
    pulses(20, 1'b0);
    check("wrap.frame", 32'(frameIndex), 32'd0);

    pulses(4, 1'b0);
    enable = 1'b0;
    pulses(8, 1'b0);
    check("hold.frame", 32'(frameIndex), 32'd1);
    enable = 1'b1;
    pulses(19, 1'b0);
    check("pre.frame", 32'(frameIndex), 32'd5);
    pulses(1, 1'b1);
    check("restart.frame", 32'(frameIndex), 32'd0);
    pulses(3, 1'b0);
    check("restart.div", 32'(frameIndex), 32'd0);
    pulses(1, 1'b0);
    check("restart.next", 32'(frameIndex), 32'd1);

    pixel("screen.in", 639, 210, 620, 200);
    check("screen.lit", 32'(pix.address), 32'd1875);
    pixel("screen.wrap", 5, 210, 620, 200);

    for (int i = 0; i < 10; i++)
      pixel("rand", 90 + int'($urandom_range(0, 50)), 190 + int'($urandom_range(0, 66)), 100, 200);

    pulses(10, 1'b0);
    check("mid.frame", 32'(frameIndex), 32'd3);
    pixel("mid.hit", 110, 220, 100, 200);
    #2;
    Reset = 1'b1;
    #1;
    check("mid.rst.addr", 32'(pix.address), 32'd0);
    check("mid.rst.on", 32'(pix.playerOn), 32'd0);
    check("mid.rst.frame", 32'(frameIndex), 32'd0);
    mFrame = 0;
    mDiv = 0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    pulses(3, 1'b0);
    check("post.div", 32'(frameIndex), 32'd0);
    pulses(1, 1'b0);
    check("post.next", 32'(frameIndex), 32'd1);
    pixel("post.hit", 110, 220, 100, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
